// File: rtl/fc_2nd_data_reader.sv
// fc_2nd_data_reader
// Read sequencer for the FC2 data RAM. After a start pulse it walks the
// RAM_Depth-entry data vector in 5-lane windows, once per output neuron, and
// presents each window to the FC2 MAC array over a valid/ready handshake.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   start               one-cycle run request, ignored while busy
//   write_active        RAM writer owns the port this cycle (write has priority)
//   data_in_0..4        RAM data_out lanes (signed)
//   Read_Enable         RAM read strobe (registered)
//   Read_Width          RAM read base address (registered)
//   win_valid/win_ready window handshake
//   win_data_0..4       captured, lane-masked window (registered)
//   win_last            last window of the current neuron pass
//   neuron_idx          neuron the current window belongs to
//   busy                run in progress
//   done                one-cycle pulse after the final window handshake
module fc_2nd_data_reader #(
    parameter int unsigned Bit_width   = 16,
    parameter int unsigned RAM_Depth   = 16,
    parameter int unsigned Num_Neurons = 10
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        start,
    input  logic                        write_active,
    input  logic signed [Bit_width-1:0] data_in_0,
    input  logic signed [Bit_width-1:0] data_in_1,
    input  logic signed [Bit_width-1:0] data_in_2,
    input  logic signed [Bit_width-1:0] data_in_3,
    input  logic signed [Bit_width-1:0] data_in_4,
    output logic                        Read_Enable,
    output logic [3:0]                  Read_Width,
    output logic                        win_valid,
    input  logic                        win_ready,
    output logic signed [Bit_width-1:0] win_data_0,
    output logic signed [Bit_width-1:0] win_data_1,
    output logic signed [Bit_width-1:0] win_data_2,
    output logic signed [Bit_width-1:0] win_data_3,
    output logic signed [Bit_width-1:0] win_data_4,
    output logic                        win_last,
    output logic [3:0]                  neuron_idx,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned LANES       = 5;
    localparam int unsigned OFF_W       = 5;
    localparam int unsigned NIDX_W      = 4;
    localparam logic [OFF_W:0]  DEPTH_X = (OFF_W+1)'(RAM_Depth);
    localparam logic [OFF_W:0]  STEP_X  = (OFF_W+1)'(LANES);
    localparam logic [NIDX_W-1:0] LAST_NEURON = NIDX_W'(Num_Neurons - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_VALID,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [OFF_W-1:0]            offset_q, offset_d;
    logic [OFF_W:0]              next_off;
    logic                        re_d, valid_d, last_d, busy_d, done_d;
    logic [NIDX_W-1:0]           nidx_d;
    logic signed [Bit_width-1:0] din   [LANES];
    logic signed [Bit_width-1:0] wd_q  [LANES];
    logic signed [Bit_width-1:0] wd_d  [LANES];

    // Lane views for indexed capture
    always_comb begin
        din[0] = data_in_0;
        din[1] = data_in_1;
        din[2] = data_in_2;
        din[3] = data_in_3;
        din[4] = data_in_4;
    end

    assign Read_Width = offset_q[3:0];
    assign win_data_0 = wd_q[0];
    assign win_data_1 = wd_q[1];
    assign win_data_2 = wd_q[2];
    assign win_data_3 = wd_q[3];
    assign win_data_4 = wd_q[4];

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        re_d     = Read_Enable;
        valid_d  = win_valid;
        last_d   = win_last;
        nidx_d   = neuron_idx;
        busy_d   = busy;
        done_d   = 1'b0;
        for (int unsigned k = 0; k < LANES; k++) begin
            wd_d[k] = wd_q[k];
        end
        // One bit wider than the offset so the end-of-vector compare cannot wrap
        next_off = {1'b0, offset_q} + STEP_X;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_ISSUE;
                    offset_d = '0;
                    nidx_d   = '0;
                    busy_d   = 1'b1;
                    re_d     = 1'b1;
                end
            end
            S_ISSUE: begin
                // A concurrent write wins the RAM port, so the read is retried
                if (!write_active) begin
                    state_d = S_VALID;
                    re_d    = 1'b0;
                    valid_d = 1'b1;
                    last_d  = (next_off >= DEPTH_X);
                    for (int unsigned k = 0; k < LANES; k++) begin
                        if (({1'b0, offset_q} + (OFF_W+1)'(k)) >= DEPTH_X) begin
                            wd_d[k] = '0;
                        end else begin
                            wd_d[k] = din[k];
                        end
                    end
                end
            end
            S_VALID: begin
                if (win_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (next_off < DEPTH_X) begin
                        state_d  = S_ISSUE;
                        offset_d = next_off[OFF_W-1:0];
                        re_d     = 1'b1;
                    end else if (neuron_idx < LAST_NEURON) begin
                        state_d  = S_ISSUE;
                        offset_d = '0;
                        nidx_d   = neuron_idx + NIDX_W'(1);
                        re_d     = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            offset_q    <= '0;
            Read_Enable <= 1'b0;
            win_valid   <= 1'b0;
            win_last    <= 1'b0;
            neuron_idx  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            for (int unsigned k = 0; k < LANES; k++) begin
                wd_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            Read_Enable <= re_d;
            win_valid   <= valid_d;
            win_last    <= last_d;
            neuron_idx  <= nidx_d;
            busy        <= busy_d;
            done        <= done_d;
            for (int unsigned k = 0; k < LANES; k++) begin
                wd_q[k] <= wd_d[k];
            end
        end
    end

endmodule
